programmable_irq_controller: RTL

Parametrised successor to the 16-line external interrupt controller: aggregates `NumIrqs` peripheral interrupt lines into one CPU external-interrupt request, with per-line level/rising-edge trigger selection, software set/clear of pending bits, and readable pending status. Sits on the peripheral Wishbone bus as a single-cycle slave and drives the core's external IRQ input. Arbitration is fixed priority, with the lowest index winning. Exactly one interrupt is presented at a time.

---
 rtl/programmable_irq_controller_if.sv | 23 ++
 rtl/programmable_irq_controller.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/programmable_irq_controller_if.sv
// Wishbone bus carrying the register accesses of programmable_irq_controller.
// The master drives the request fields; the slave answers with rdata/ack/err in the same cycle.
interface wb_bus;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  modport master (
    output cyc, stb, we, sel, addr, wdata,
    input  rdata, ack, err
  );

  modport slave (
    input  cyc, stb, we, sel, addr, wdata,
    output rdata, ack, err
  );
endinterface

// File: rtl/programmable_irq_controller.sv
// Fixed-priority interrupt aggregator with a single-cycle Wishbone register block.
// Optional macro PIC_EDGE_MODE_EN adds the MODE register and per-line rising-edge capture.
module programmable_irq_controller #(
  parameter logic [31:0] BaseAddr = 32'h4010,
  parameter int          NumIrqs  = 16
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic [NumIrqs-1:0] irq_lines_in,
  output logic               ext_irq_out,
  output logic               ext_irq_clr_out,
  wb_bus.slave               bus_slave
);

  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFFF >> (32 - NumIrqs);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t      r_state;
  logic [4:0]  r_irqnum;
  logic [31:0] r_mask;
  logic [31:0] r_pend;
`ifdef PIC_EDGE_MODE_EN
  logic [31:0] r_mode;
  logic [31:0] r_line_q;
`endif

  state_t      w_state_nxt;
  logic [4:0]  w_irqnum_nxt;
  logic [31:0] w_lines;
  logic [31:0] w_hit;
  logic [31:0] w_bm;
  logic [31:0] w_wval;
  logic [31:0] w_clr;
  logic [31:0] w_set;
  logic [31:0] w_pend_nxt;
  logic [31:0] w_cand;
  logic [4:0]  w_win;
  logic [31:0] w_irqbit;
  logic        w_req;
  logic        w_err;
  logic        w_ack;
  logic        w_wr;
  logic        w_active_clr;
  logic        w_is_mask;
  logic        w_is_pend;
  logic        w_is_num;
  logic        w_is_bit;
  logic        w_is_mode;
  logic        w_is_setp;
  logic        w_mapped;

  // Address decode and bus response
  always_comb begin
    w_is_mask = (bus_slave.addr == BaseAddr);
    w_is_pend = (bus_slave.addr == BaseAddr + 32'h04);
    w_is_num  = (bus_slave.addr == BaseAddr + 32'h08);
    w_is_bit  = (bus_slave.addr == BaseAddr + 32'h0C);
`ifdef PIC_EDGE_MODE_EN
    w_is_mode = (bus_slave.addr == BaseAddr + 32'h10);
`else
    w_is_mode = 1'b0;
`endif
    w_is_setp = (bus_slave.addr == BaseAddr + 32'h14);
    w_mapped  = w_is_mask | w_is_pend | w_is_num | w_is_bit | w_is_mode | w_is_setp;
    w_req     = bus_slave.cyc & bus_slave.stb;
    w_err     = w_req & (~w_mapped |
                         (bus_slave.we & ((bus_slave.sel == 4'b0000) | w_is_num | w_is_bit)));
    w_ack     = w_req & ~w_err;
    w_wr      = w_ack & bus_slave.we;
    w_bm      = {{8{bus_slave.sel[3]}}, {8{bus_slave.sel[2]}},
                 {8{bus_slave.sel[1]}}, {8{bus_slave.sel[0]}}};
    w_wval    = bus_slave.wdata & w_bm & LINE_MASK;
  end

  assign w_irqbit = (r_state == S_ACTIVE) ? (32'd1 << r_irqnum) : 32'd0;

  always_comb begin
    bus_slave.rdata = 32'd0;
    if (w_ack) begin
      if (w_is_mask) bus_slave.rdata = r_mask;
      if (w_is_pend) bus_slave.rdata = r_pend;
      if (w_is_num)  bus_slave.rdata = {27'd0, r_irqnum};
      if (w_is_bit)  bus_slave.rdata = w_irqbit;
`ifdef PIC_EDGE_MODE_EN
      if (w_is_mode) bus_slave.rdata = r_mode;
`endif
    end
  end

  assign bus_slave.ack = w_ack;
  assign bus_slave.err = w_err;

  // Capture, pending update and candidate selection
  always_comb begin
    w_lines = 32'd0;
    w_lines[NumIrqs-1:0] = irq_lines_in;
`ifdef PIC_EDGE_MODE_EN
    w_hit = w_lines & ~(r_mode & r_line_q);
`else
    w_hit = w_lines;
`endif
    w_clr      = (w_wr & w_is_pend) ? w_wval : 32'd0;
    w_set      = (w_wr & w_is_setp) ? w_wval : 32'd0;
    w_pend_nxt = (r_pend & ~w_clr) | w_set | w_hit;
    w_cand     = w_pend_nxt & r_mask;
    w_win      = 5'd0;
    // Scan downwards so the lowest set index is the one left standing
    for (int i = 31; i >= 0; i--) begin
      if (w_cand[i]) w_win = 5'(i);
    end
  end

  // Arbitration FSM: next state
  always_comb begin
    w_state_nxt  = r_state;
    w_irqnum_nxt = r_irqnum;
    w_active_clr = (r_state == S_ACTIVE) & w_clr[r_irqnum];
    if ((r_state == S_IDLE) || w_active_clr) begin
      if (w_cand != 32'd0) begin
        w_state_nxt  = S_ACTIVE;
        w_irqnum_nxt = w_win;
      end else begin
        w_state_nxt  = S_IDLE;
        w_irqnum_nxt = 5'd0;
      end
    end
  end

  // Register update
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state  <= S_IDLE;
      r_irqnum <= 5'd0;
      r_mask   <= 32'd0;
      r_pend   <= 32'd0;
`ifdef PIC_EDGE_MODE_EN
      r_mode   <= 32'd0;
      r_line_q <= 32'd0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_irqnum <= w_irqnum_nxt;
      r_pend   <= w_pend_nxt;
      if (w_wr & w_is_mask) r_mask <= ((r_mask & ~w_bm) | w_wval) & LINE_MASK;
`ifdef PIC_EDGE_MODE_EN
      if (w_wr & w_is_mode) r_mode <= ((r_mode & ~w_bm) | w_wval) & LINE_MASK;
      r_line_q <= w_lines;
`endif
    end
  end

  assign ext_irq_out     = (r_state == S_ACTIVE);
  assign ext_irq_clr_out = ~ext_irq_out;

endmodule
